ifetch_line_responder: RTL
==========================

// Module: ifetch_line_responder
// PURPOSE
//  Instruction-side responder feeding the fetch stage a 4-instruction aligned line
//  (4*INSN_LEN bits) for a requested PC; fetch selects the word via pc[3:2].
//  Holds one line buffer (tag + valid); on hit returns the buffered line, on miss
//  fills it from a 32-bit-beat backing memory (4 beats), then responds.
//  Sits between the fetch PC register and the instruction memory port.
// PARAMETERS
//  ADDR_W   `ADDR_LEN  PC / memory address width
//  DATA_W   `INSN_LEN  instruction / memory beat width
// PORTS
//  clk_i              in   1         clock, all state on rising edge
//  reset_i            in   1         asynchronous, active-high reset
//  req_valid_i        in   1         fetch request valid
//  req_ready_o        out  1         responder can accept request (IDLE only)
//  req_pc_i           in   ADDR_W    requested PC (line = pc[ADDR_W-1:4])
//  resp_valid_o       out  1         line response valid
//  resp_ready_i       in   1         fetch consumes response
//  resp_idata_o       out  4*DATA_W  line; word k at [32k+31:32k]
//  mem_req_valid_o    out  1         memory read request valid
//  mem_req_ready_i    in   1         memory accepts request
//  mem_addr_o         out  ADDR_W    word address {tag, beat[1:0], 2'b00}
//  mem_rdata_valid_i  in   1         read data beat valid (in request order)
//  mem_rdata_i        in   DATA_W    read data beat
//  flush_i            in   1         invalidate line buffer
// BEHAVIOUR
//  - States IDLE, FILL, RESP. Reset (async): state=IDLE, valid_q=0, tag_q=0,
//    counters=0, resp_idata_o=0; while reset_i=1 all outputs 0 incl. req_ready_o.
//  - req_ready_o = (state==IDLE) & ~reset_i. Handshake on valid&ready same edge.
//  - IDLE accept, hit (valid_q & tag_q==req_pc_i[ADDR_W-1:4] & ~flush_i): -> RESP;
//    resp_valid_o=1 next cycle (1-cycle latency), data = buffer.
//  - IDLE accept, miss: latch tag, -> FILL; valid_q cleared at entry.
//  - FILL: req counter (0..4) issues mem_req_valid_o until 4 requests accepted;
//    address advances only on mem_req_valid_o&mem_req_ready_i. Up to 4 outstanding.
//    Data counter writes each mem_rdata_valid_i beat into word slot of the
//    matching issued beat. 4th data beat -> valid_q=1, -> RESP next cycle.
//    Data beats never exceed accepted requests (memory contract; not checked).
//  - RESP: resp_valid_o=1, resp_idata_o stable until resp_ready_i; on handshake
//    -> IDLE, resp_valid_o=0 next cycle. No new request accepted in RESP/FILL.
//  - mem_rdata_valid_i outside FILL ignored.
//  - flush_i: valid_q<=0 that edge. During FILL the fill completes and the
//    response is still delivered, but valid_q stays 0 (flush remembered in a
//    sticky bit until FILL exits). flush_i coincident with 4th beat -> valid_q=0.
//  - flush_i coincident with IDLE request -> treated as miss.
//  - reset_i mid-FILL/RESP: abandon, IDLE, valid_q=0; late memory beats ignored.
// CONFIGURATION
//  IFLR_CRITICAL_WORD_FIRST_EN defined: fill beat order starts at req_pc_i[3:2]
//    and wraps mod 4 (e.g. 2,3,0,1); data written to the matching slots.
//  Undefined: fill order always 0,1,2,3. Response timing identical either way.
// TESTING
//  1 Reset then req pc=0x100, mem returns 11,22,33,44 one/cycle -> mem_addr
//    0x100,0x104,0x108,0x10C; resp_idata_o=0x00000044_00000033_00000022_00000011.
//  2 Repeat req pc=0x108 after 1 -> no mem request; resp_valid_o 1 cycle after accept,
//    same line.
//  3 resp_ready_i held 0 for 5 cycles -> resp_valid_o/resp_idata_o stable,
//    req_ready_o=0 throughout; release -> IDLE next cycle.
//  4 flush_i pulse during FILL of pc=0x200 -> response still delivered; next
//    req pc=0x204 misses and refetches 0x200..0x20C.
//  5 mem_req_ready_i toggling 1,0,0,1,... -> exactly 4 requests, addresses in
//    order, no duplicate; with IFLR_CRITICAL_WORD_FIRST_EN pc=0x308 -> 0x308,
//    0x30C,0x300,0x304, line slots correct.
//  6 reset_i asserted after 2 beats -> outputs 0 immediately; later beats ignored;
//    next req pc=0x100 misses.

Source files
------------

// File: rtl/ifetch_line_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_line_responder
//  Purpose  : Instruction-side line responder. It keeps one buffered line of
//             4 instructions (tag + valid) and returns it to the fetch stage
//             for any PC inside that line. On a miss it fills the line from a
//             32-bit-beat backing memory (4 read beats, up to 4 outstanding)
//             and then responds.
//  Ports    : clk_i / reset_i        clock, asynchronous active-high reset
//             req_valid_i/req_ready_o/req_pc_i        fetch request channel
//             resp_valid_o/resp_ready_i/resp_idata_o  line response channel
//             mem_req_valid_o/mem_req_ready_i/mem_addr_o  memory read request
//             mem_rdata_valid_i/mem_rdata_i               memory read data
//             flush_i                invalidate the line buffer
//  Config   : IFLR_CRITICAL_WORD_FIRST_EN - when defined, the fill starts at
//             the requested word (req_pc_i[3:2]) and wraps modulo 4; when
//             undefined the fill order is always 0,1,2,3.
//  Revision : 1.0 - initial release
// ============================================================================

`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef INSN_LEN
`define INSN_LEN 32
`endif

module ifetch_line_responder #(
  parameter int ADDR_W = `ADDR_LEN,
  parameter int DATA_W = `INSN_LEN
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_W-1:0]     req_pc_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [4*DATA_W-1:0]   resp_idata_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_W-1:0]     mem_addr_o,
  input  logic                  mem_rdata_valid_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  flush_i
);

  localparam int TAG_W = ADDR_W - 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_valid;
  logic [TAG_W-1:0]     r_tag;
  logic [2:0]           r_req_cnt;     // requests accepted by memory, 0..4
  logic [1:0]           r_dat_cnt;     // data beats received, 0..3
  logic                 r_flush_seen;  // flush observed during the current fill
  logic [4*DATA_W-1:0]  r_line;

  logic                 w_req_ready;
  logic                 w_resp_valid;
  logic                 w_mem_req_valid;
  logic                 w_accept;
  logic                 w_hit;
  logic                 w_beat_in;
  logic                 w_last_beat;
  logic [1:0]           w_base;
  logic [1:0]           w_issue_beat;
  logic [1:0]           w_wr_slot;
  logic [TAG_W-1:0]     w_req_tag;
  logic                 w_unused_pc;

  assign w_req_tag   = req_pc_i[ADDR_W-1:4];
  // Word-select bits are consumed by fetch, not here (except for the
  // critical-word start position).
  assign w_unused_pc = ^req_pc_i[3:0];

`ifdef IFLR_CRITICAL_WORD_FIRST_EN
  logic [1:0] r_base;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_base <= 2'b00;
    end else if (w_accept && !w_hit) begin
      r_base <= req_pc_i[3:2];
    end
  end

  assign w_base = r_base;
`else
  assign w_base = 2'b00;
`endif

  // Beat positions wrap naturally in 2 bits, giving the modulo-4 fill order.
  assign w_issue_beat = w_base + r_req_cnt[1:0];
  assign w_wr_slot    = w_base + r_dat_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready     = 1'b0;
    w_resp_valid    = 1'b0;
    w_mem_req_valid = 1'b0;
    w_accept        = 1'b0;
    w_beat_in       = 1'b0;
    w_last_beat     = 1'b0;
    // A flush on the request cycle forces a miss.
    w_hit           = r_valid && (r_tag == w_req_tag) && !flush_i;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = w_hit ? S_RESP : S_FILL;
        end
      end
      S_FILL: begin
        w_mem_req_valid = ~r_req_cnt[2];
        w_beat_in       = mem_rdata_valid_i;
        if (mem_rdata_valid_i && (r_dat_cnt == 2'd3)) begin
          w_last_beat = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        w_resp_valid = 1'b1;
        if (resp_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_valid      <= 1'b0;
      r_tag        <= '0;
      r_req_cnt    <= 3'd0;
      r_dat_cnt    <= 2'd0;
      r_flush_seen <= 1'b0;
      r_line       <= '0;
    end else begin
      if (w_accept && !w_hit) begin
        r_tag        <= w_req_tag;
        r_valid      <= 1'b0;
        r_req_cnt    <= 3'd0;
        r_dat_cnt    <= 2'd0;
        r_flush_seen <= 1'b0;
      end

      if (w_mem_req_valid && mem_req_ready_i) begin
        r_req_cnt <= r_req_cnt + 3'd1;
      end

      if (w_beat_in) begin
        for (int k = 0; k < 4; k++) begin
          if (w_wr_slot == 2'(k)) begin
            r_line[k*DATA_W +: DATA_W] <= mem_rdata_i;
          end
        end
        r_dat_cnt <= r_dat_cnt + 2'd1;
      end

      // A flush seen at any point of the fill keeps the new line invalid,
      // although the response for it is still delivered.
      if (w_last_beat) begin
        r_valid <= ~(r_flush_seen | flush_i);
      end

      if (flush_i) begin
        r_valid <= 1'b0;
        if (r_state == S_FILL) begin
          r_flush_seen <= 1'b1;
        end
      end
    end
  end

  assign req_ready_o     = w_req_ready & ~reset_i;
  assign resp_valid_o    = w_resp_valid;
  assign resp_idata_o    = r_line;
  assign mem_req_valid_o = w_mem_req_valid;
  assign mem_addr_o      = {r_tag, w_issue_beat, 2'b00};

endmodule
`default_nettype wire
